// File: rtl/seq_pkg.sv
// seq_pkg: shared types and default sizes for the seqpu memory arbiter.
package seq_pkg;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;
    localparam int WAIT_MAX_DEF = 4;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU_RD, OWN_DMA_RD} owner_e;
endpackage

// File: rtl/seq_mem_arbiter_if.sv
// seq_mem_arbiter_if: CPU request port, DMA request port and shared memory port bundle.
interface seq_mem_arbiter_if
    import seq_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          cpu_req;
    logic [AW-1:0] cpu_address;
    logic          cpu_wren_n;
    logic [DW-1:0] cpu_data_out;
    logic          cpu_gnt;
    logic [DW-1:0] cpu_data_in;
    logic          cpu_rvalid;
    logic          dma_req;
    logic [AW-1:0] dma_address;
    logic          dma_wren_n;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic [DW-1:0] dma_rdata;
    logic          dma_rvalid;
    logic [AW-1:0] address;
    logic [DW-1:0] data_out;
    logic          wren_n;
    logic [DW-1:0] data_in;
    modport slave (
        input  cpu_req, cpu_address, cpu_wren_n, cpu_data_out,
        input  dma_req, dma_address, dma_wren_n, dma_wdata, data_in,
        output cpu_gnt, cpu_data_in, cpu_rvalid, dma_gnt, dma_rdata, dma_rvalid,
        output address, data_out, wren_n
    );
    modport master (
        output cpu_req, cpu_address, cpu_wren_n, cpu_data_out,
        output dma_req, dma_address, dma_wren_n, dma_wdata, data_in,
        input  cpu_gnt, cpu_data_in, cpu_rvalid, dma_gnt, dma_rdata, dma_rvalid,
        input  address, data_out, wren_n
    );
endinterface

// File: rtl/seq_mem_arbiter.sv
// seq_mem_arbiter: shares one synchronous memory port between the CPU and a DMA master.
// Define ARB_STARVE_GUARD_EN to let a long-waiting DMA request pre-empt the CPU.
module seq_mem_arbiter
    import seq_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF,
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input logic clk,
    input logic rst_n,
    seq_mem_arbiter_if.slave bus
);
    if (WAIT_MAX < 1 || WAIT_MAX > 15) begin : g_bad_wait_max
        $error("WAIT_MAX must be in 1..15");
    end
    owner_e owner_q, owner_d;
    logic cpu_win, dma_win, force_dma;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;
    logic wren_mux;
`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] wait_q, wait_d;
    assign force_dma = bus.dma_req && (wait_q == 4'(WAIT_MAX));
    always_comb begin
        wait_d = wait_q;
        if (!bus.dma_req || dma_win) wait_d = '0;
        else if (wait_q < 4'(WAIT_MAX)) wait_d = wait_q + 4'd1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_q <= '0;
        else wait_q <= wait_d;
    end
`else
    assign force_dma = 1'b0;
`endif
    // Grants are gated by rst_n so nothing is issued while the system is held in reset.
    always_comb begin
        cpu_win = rst_n && bus.cpu_req && !force_dma;
        dma_win = rst_n && bus.dma_req && !cpu_win;
        addr_mux = dma_win ? bus.dma_address : bus.cpu_address;
        wdata_mux = dma_win ? bus.dma_wdata : bus.cpu_data_out;
        wren_mux = cpu_win ? bus.cpu_wren_n : dma_win ? bus.dma_wren_n : 1'b1;
        owner_d = (cpu_win && bus.cpu_wren_n) ? OWN_CPU_RD :
                  (dma_win && bus.dma_wren_n) ? OWN_DMA_RD : OWN_NONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) owner_q <= OWN_NONE;
        else owner_q <= owner_d;
    end
    assign bus.cpu_gnt = cpu_win;
    assign bus.dma_gnt = dma_win;
    assign bus.address = addr_mux;
    assign bus.data_out = wdata_mux;
    assign bus.wren_n = wren_mux;
    assign bus.cpu_data_in = bus.data_in;
    assign bus.dma_rdata = bus.data_in;
    assign bus.cpu_rvalid = (owner_q == OWN_CPU_RD);
    assign bus.dma_rvalid = (owner_q == OWN_DMA_RD);
endmodule
